lpddr5_cmd_sched: RTL and testbench
===================================

Name: lpddr5_cmd_sched

Overview:
Command scheduler in front of the lpddr5_channel command pins (CS0, ADDR15).
- Arbitrates three sources onto one command slot per clock:
  - periodic refresh (internal timer),
  - mode-register read/write requests from the config path,
  - read requests from the bus side.
- Enforces refresh interval, refresh-busy time and per-command gap timing.
- Passes busID through with reads, so returned data can be routed.

Parameters:
REFI_CYC, 3900, clk cycles between refresh due events
RFC_CYC, 280, clk cycles the channel is blocked after a refresh command
RD_GAP, 4, clk cycles after a read command (command cycle included) before the next command
REG_GAP, 10, clk cycles after a register command (final cycle included) before the next command
MAX_POSTPONE, 8, pending refresh count at which refresh becomes urgent
ADDR15_REFRESH, 15'h700f, ADDR15 encoding of refresh
CS0_REFRESH, 1'b1, CS0 value during refresh
ADDR15_RDREG, 15'h7e00, register read base, OR'd with reg_no
ADDR15_WRREG, 15'h7f00, register write base, OR'd with reg_no
CS0_REG, 1'b1, CS0 value on register command cycle

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-low reset (0 = reset)
rd_valid  in  1  read request present
rd_ready  out  1  read request accepted this cycle
rd_addr  in  15  read row/column address
rd_busID  in  9  requester tag
reg_valid  in  1  register request present
reg_ready  out  1  register request accepted this cycle
reg_wr  in  1  1 = write, 0 = read
reg_no  in  8  register number
reg_data  in  8  register write data
cmd_valid  out  1  command slot carries a command
cmd_CS0  out  1  CS0 value for this slot
cmd_ADDR15  out  15  ADDR15 value for this slot
cmd_busID  out  9  tag; valid only with a read command
cmd_is_read  out  1  slot is a data read
ref_pending  out  4  postponed refresh count
ref_busy  out  1  inside the RFC_CYC window

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0; ref_pending 0; state IDLE.
  - Refresh timer loads REFI_CYC-1.
  - Reset mid-command aborts the command; no partial second cycle.
- Refresh timer:
  - decrements every cycle; at 0 it reloads REFI_CYC-1 and ref_pending increments.
  - ref_pending saturates at MAX_POSTPONE.
  - Timer runs in every state.
- Outputs are registered: a command is driven the cycle after the grant decision.
  - Handshake fire = valid & ready. ready is combinational, asserted only in IDLE for the single granted source.
  - Requester must hold valid and payload stable until fire.
- States: IDLE, REF, REG_WR2, GAP.
- IDLE arbitration, evaluated each cycle, first match wins:
  1. ref_pending==MAX_POSTPONE → refresh.
  2. reg_valid → register.
  3. rd_valid → read.
  4. ref_pending!=0 → refresh.
  5. Otherwise no command.
- Refresh:
  - cmd_valid=1, cmd_CS0=CS0_REFRESH, cmd_ADDR15=ADDR15_REFRESH.
  - ref_pending decrements; go to REF.
  - A timer-due event in the same cycle nets to no change in ref_pending.
- REF: ref_busy=1 for RFC_CYC cycles total (issue cycle included), then IDLE.
- Register read:
  - one cycle: CS0_REG, ADDR15 = ADDR15_RDREG | {7'b0, reg_no}.
  - Then GAP with count REG_GAP.
- Register write:
  - cycle 1: CS0_REG, ADDR15 = ADDR15_WRREG | {7'b0, reg_no}; go to REG_WR2.
  - cycle 2: cmd_valid=1, CS0=0, ADDR15 = {7'b0, reg_data captured at fire}.
  - Then GAP with count REG_GAP, measured from cycle 2.
- Read:
  - CS0=0, ADDR15=rd_addr, cmd_is_read=1, cmd_busID=rd_busID.
  - Then GAP with count RD_GAP.
- GAP: down-counter; no ready asserted, cmd_valid=0; IDLE when the count expires. Gap count includes the command cycle.
- Refresh ceiling: refresh is never postponed beyond MAX_POSTPONE. Continuous rd_valid therefore yields to refresh once ref_pending hits the ceiling.
- cmd_busID and cmd_is_read are 0 on non-read slots.

Decomposition:
- Shared package lpddr5_pkg:
  - command encodings (ADDR15_* / CS0_* constants),
  - timing defaults,
  - state enum,
  - busID width (9).
- One natural sub-module: lpddr5_ref_timer (interval counter plus saturating pending counter, with a decrement input).
- Arbiter and FSM stay in the top.

Test Plan:
- Reset, then idle with REFI_CYC=16, RFC_CYC=5 → first refresh cmd (ADDR15=0x700f, CS0=1) 18 cycles after rst release; ref_busy high 5 cycles.
- reg_valid, reg_wr=1, reg_no=0x12, reg_data=0xA5 → two consecutive slots 0x7f12/CS0=1 then 0x00A5/CS0=0; reg_ready again no earlier than REG_GAP cycles after slot 2.
- rd_valid held with addr=0x1234, busID=0x1AB; concurrent reg_valid (read, reg_no=3) → 0x7e03 issued first, read follows after REG_GAP, with cmd_busID=0x1AB.
- rd_valid held continuously with REFI_CYC=16 → reads win until ref_pending=8; then a refresh is forced; ref_pending never exceeds 8.
- Timer expiry on the same cycle a refresh is issued → ref_pending unchanged.
- Assert rst low during REG_WR2 → no data slot follows; all outputs 0 immediately (asynchronously); first command after release obeys arbitration.

Source files
------------

// File: rtl/lpddr5_pkg.sv
// Shared definitions for the LPDDR5 command scheduler: encodings, timing defaults, state types.
package lpddr5_pkg;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned BUS_ID_W = 9;
    localparam int unsigned REG_NO_W = 8;
    localparam int unsigned PEND_W   = 4;

    // Timing defaults in clk cycles
    localparam int unsigned REFI_CYC_DEF     = 3900;
    localparam int unsigned RFC_CYC_DEF      = 280;
    localparam int unsigned RD_GAP_DEF       = 4;
    localparam int unsigned REG_GAP_DEF      = 10;
    localparam int unsigned MAX_POSTPONE_DEF = 8;

    // Command pin encodings
    localparam logic [ADDR_W-1:0] ADDR15_REFRESH = 15'h700f;
    localparam logic [ADDR_W-1:0] ADDR15_RDREG   = 15'h7e00;
    localparam logic [ADDR_W-1:0] ADDR15_WRREG   = 15'h7f00;
    localparam logic              CS0_REFRESH    = 1'b1;
    localparam logic              CS0_REG        = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRef,
        StRegWr2,
        StGap
    } sched_state_e;

    typedef enum logic [1:0] {
        GrNone,
        GrRef,
        GrReg,
        GrRd
    } grant_e;

    // First-cycle ADDR15 of a register command
    function automatic logic [ADDR_W-1:0] reg_cmd_addr(input logic wr,
                                                       input logic [REG_NO_W-1:0] reg_no);
        return (wr ? ADDR15_WRREG : ADDR15_RDREG) | {7'b0, reg_no};
    endfunction

endpackage

// File: rtl/lpddr5_cmd_sched_if.sv
// Request/command bundle between requesters, scheduler and the channel command pins.
interface lpddr5_cmd_sched_if;
    import lpddr5_pkg::*;

    logic                rd_valid;
    logic                rd_ready;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BUS_ID_W-1:0] rd_busID;

    logic                reg_valid;
    logic                reg_ready;
    logic                reg_wr;
    logic [REG_NO_W-1:0] reg_no;
    logic [7:0]          reg_data;

    logic                cmd_valid;
    logic                cmd_CS0;
    logic [ADDR_W-1:0]   cmd_ADDR15;
    logic [BUS_ID_W-1:0] cmd_busID;
    logic                cmd_is_read;
    logic [PEND_W-1:0]   ref_pending;
    logic                ref_busy;

    // Requester / observer side
    modport master (
        output rd_valid, rd_addr, rd_busID, reg_valid, reg_wr, reg_no, reg_data,
        input  rd_ready, reg_ready, cmd_valid, cmd_CS0, cmd_ADDR15, cmd_busID, cmd_is_read,
               ref_pending, ref_busy
    );

    // Scheduler side
    modport slave (
        input  rd_valid, rd_addr, rd_busID, reg_valid, reg_wr, reg_no, reg_data,
        output rd_ready, reg_ready, cmd_valid, cmd_CS0, cmd_ADDR15, cmd_busID, cmd_is_read,
               ref_pending, ref_busy
    );

endinterface

// File: rtl/lpddr5_ref_timer.sv
// Refresh interval timer with a saturating count of refreshes still owed.
module lpddr5_ref_timer
    import lpddr5_pkg::*;
#(
    parameter int unsigned REFI_CYC     = REFI_CYC_DEF,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_i,
    output logic [PEND_W-1:0] pending_o
);

    localparam int unsigned TimerW = $clog2(REFI_CYC + 1);
    localparam logic [TimerW-1:0] Reload  = TimerW'(REFI_CYC - 1);
    localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_POSTPONE);

    logic [TimerW-1:0] timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              due;

    assign due       = (timer_q == '0);
    assign pending_o = pend_q;

    // Next timer value and pending count; a due event and a refresh issue cancel out
    always_comb begin
        timer_d = due ? Reload : timer_q - TimerW'(1);
        pend_d  = pend_q;
        case ({due, dec_i})
            2'b10: if (pend_q != PendMax) pend_d = pend_q + PEND_W'(1);
            2'b01: if (pend_q != '0)      pend_d = pend_q - PEND_W'(1);
            default: ;
        endcase
    end

    // Timer and pending registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= Reload;
            pend_q  <= '0;
        end else begin
            timer_q <= timer_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/lpddr5_cmd_sched.sv
// Arbitrates refresh, register and read requests onto one registered command slot per clock.
module lpddr5_cmd_sched
    import lpddr5_pkg::*;
#(
    parameter int unsigned REFI_CYC     = REFI_CYC_DEF,
    parameter int unsigned RFC_CYC      = RFC_CYC_DEF,
    parameter int unsigned RD_GAP       = RD_GAP_DEF,
    parameter int unsigned REG_GAP      = REG_GAP_DEF,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEF
) (
    input logic                clk,
    input logic                rst,
    lpddr5_cmd_sched_if.slave  bus
);

    localparam int unsigned CntMaxA = (RFC_CYC > REG_GAP) ? RFC_CYC : REG_GAP;
    localparam int unsigned CntMax  = (CntMaxA > RD_GAP) ? CntMaxA : RD_GAP;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam logic [PEND_W-1:0] PendMax = PEND_W'(MAX_POSTPONE);

    sched_state_e        state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                cmd_cs0_q, cmd_cs0_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [BUS_ID_W-1:0] cmd_bus_id_q, cmd_bus_id_d;
    logic                cmd_is_read_q, cmd_is_read_d;
    logic [PEND_W-1:0]   pending;
    grant_e              grant;

    lpddr5_ref_timer #(
        .REFI_CYC     (REFI_CYC),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_ref_timer (
        .clk       (clk),
        .rst       (rst),
        .dec_i     (grant == GrRef),
        .pending_o (pending)
    );

    // Fixed-priority arbitration, only while idle; a full postpone budget beats everything
    always_comb begin
        grant = GrNone;
        if (state_q == StIdle) begin
            if (pending == PendMax)  grant = GrRef;
            else if (bus.reg_valid)  grant = GrReg;
            else if (bus.rd_valid)   grant = GrRd;
            else if (pending != '0)  grant = GrRef;
        end
    end

    // Ready is forced low while reset is held so nothing can fire during reset
    assign bus.rd_ready  = rst && (grant == GrRd);
    assign bus.reg_ready = rst && (grant == GrReg);

    // FSM next state and next command slot; slots default to empty
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_data_d     = wr_data_q;
        cmd_valid_d   = 1'b0;
        cmd_cs0_d     = 1'b0;
        cmd_addr_d    = '0;
        cmd_bus_id_d  = '0;
        cmd_is_read_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                unique case (grant)
                    GrRef: begin
                        cmd_valid_d = 1'b1;
                        cmd_cs0_d   = CS0_REFRESH;
                        cmd_addr_d  = ADDR15_REFRESH;
                        state_d     = StRef;
                        cnt_d       = CntW'(RFC_CYC - 1);
                    end
                    GrReg: begin
                        cmd_valid_d = 1'b1;
                        cmd_cs0_d   = CS0_REG;
                        cmd_addr_d  = reg_cmd_addr(bus.reg_wr, bus.reg_no);
                        if (bus.reg_wr) begin
                            state_d   = StRegWr2;
                            wr_data_d = bus.reg_data;
                        end else begin
                            state_d = StGap;
                            cnt_d   = CntW'(REG_GAP - 1);
                        end
                    end
                    GrRd: begin
                        cmd_valid_d   = 1'b1;
                        cmd_addr_d    = bus.rd_addr;
                        cmd_bus_id_d  = bus.rd_busID;
                        cmd_is_read_d = 1'b1;
                        state_d       = StGap;
                        cnt_d         = CntW'(RD_GAP - 1);
                    end
                    default: ;
                endcase
            end
            StRegWr2: begin
                // Data cycle of a register write; the gap counts from here
                cmd_valid_d = 1'b1;
                cmd_addr_d  = {7'b0, wr_data_q};
                state_d     = StGap;
                cnt_d       = CntW'(REG_GAP - 1);
            end
            StRef, StGap: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered command outputs; reset aborts any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_data_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_cs0_q     <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_bus_id_q  <= '0;
            cmd_is_read_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_data_q     <= wr_data_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_cs0_q     <= cmd_cs0_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_bus_id_q  <= cmd_bus_id_d;
            cmd_is_read_q <= cmd_is_read_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_CS0     = cmd_cs0_q;
    assign bus.cmd_ADDR15  = cmd_addr_q;
    assign bus.cmd_busID   = cmd_bus_id_q;
    assign bus.cmd_is_read = cmd_is_read_q;
    assign bus.ref_pending = pending;
    assign bus.ref_busy    = (state_q == StRef);

endmodule

// File: tb/tb_lpddr5_cmd_sched.sv
// Randomized bench for lpddr5_cmd_sched against a cycle-numbered reference model.
module tb_lpddr5_cmd_sched;

    localparam int unsigned REFI = 16;
    localparam int unsigned RFC  = 5;
    localparam int unsigned RDG  = 4;
    localparam int unsigned REGG = 10;
    localparam int unsigned MAXP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lpddr5_cmd_sched_if bus();

    lpddr5_cmd_sched #(
        .REFI_CYC     (REFI),
        .RFC_CYC      (RFC),
        .RD_GAP       (RDG),
        .REG_GAP      (REGG),
        .MAX_POSTPONE (MAXP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        v;
        logic        cs0;
        logic [14:0] a;
        logic [8:0]  id;
        logic        rd;
    } slot_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycle 1 is the first cycle after reset release
    int    cyc;
    int    next_free;
    int    busy_from;
    int    busy_to;
    int    pend;
    slot_t exp_q[int];

    // Requester state, held until the model says the request fired
    bit          rd_req;
    logic [14:0] rd_a;
    logic [8:0]  rd_id;
    bit          reg_req;
    bit          reg_w;
    logic [7:0]  reg_n;
    logic [7:0]  reg_d;

    int first_ref_cyc = 0;
    int max_pend      = 0;
    int due_on_ref    = 0;
    int last_grant    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc       = 1;
        next_free = 1;
        busy_from = 1;
        busy_to   = 0;
        pend      = 0;
        exp_q.delete();
        first_ref_cyc = 0;
    endtask

    task automatic drive();
        bus.rd_valid  = rd_req;
        bus.rd_addr   = rd_a;
        bus.rd_busID  = rd_id;
        bus.reg_valid = reg_req;
        bus.reg_wr    = reg_w;
        bus.reg_no    = reg_n;
        bus.reg_data  = reg_d;
    endtask

    task automatic gen(input int p_rd, input int p_reg);
        if (!rd_req && $urandom_range(99) < p_rd) begin
            rd_req = 1'b1;
            rd_a   = 15'($urandom);
            rd_id  = 9'($urandom);
        end
        if (!reg_req && $urandom_range(99) < p_reg) begin
            reg_req = 1'b1;
            reg_w   = 1'($urandom);
            reg_n   = 8'($urandom);
            reg_d   = 8'($urandom);
        end
    endtask

    function automatic slot_t dut_slot();
        return {bus.cmd_valid, bus.cmd_CS0, bus.cmd_ADDR15, bus.cmd_busID, bus.cmd_is_read};
    endfunction

    // One cycle: called at a falling edge, checks this cycle and advances the model
    task automatic step();
        int    g;
        int    dec;
        int    p;
        slot_t e;
        drive();
        #1;
        g = 0;
        if (cyc >= next_free) begin
            if (pend == MAXP)  g = 1;
            else if (reg_req)  g = 2;
            else if (rd_req)   g = 3;
            else if (pend > 0) g = 1;
        end
        last_grant = g;
        e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
        check_eq("cmd", 64'(dut_slot()), 64'(e));
        check_eq("ready", 64'({bus.rd_ready, bus.reg_ready}), 64'({g == 3, g == 2}));
        check_eq("ref", 64'({bus.ref_busy, bus.ref_pending}),
                 64'({(cyc >= busy_from) && (cyc <= busy_to), 4'(pend)}));
        if (bus.cmd_valid && bus.cmd_ADDR15 == 15'h700f && first_ref_cyc == 0)
            first_ref_cyc = cyc;
        if (int'(bus.ref_pending) > max_pend) max_pend = int'(bus.ref_pending);
        dec = 0;
        case (g)
            1: begin
                exp_q[cyc+1] = '{v: 1'b1, cs0: 1'b1, a: 15'h700f, id: 9'h0, rd: 1'b0};
                busy_from = cyc + 1;
                busy_to   = cyc + RFC;
                next_free = cyc + 1 + RFC;
                dec = 1;
                if (cyc % REFI == 0) due_on_ref++;
            end
            2: begin
                if (reg_w) begin
                    exp_q[cyc+1] = '{v: 1'b1, cs0: 1'b1, a: 15'h7f00 | {7'b0, reg_n}, id: 9'h0,
                                     rd: 1'b0};
                    exp_q[cyc+2] = '{v: 1'b1, cs0: 1'b0, a: {7'b0, reg_d}, id: 9'h0, rd: 1'b0};
                    next_free = cyc + 2 + REGG;
                end else begin
                    exp_q[cyc+1] = '{v: 1'b1, cs0: 1'b1, a: 15'h7e00 | {7'b0, reg_n}, id: 9'h0,
                                     rd: 1'b0};
                    next_free = cyc + 1 + REGG;
                end
                reg_req = 1'b0;
            end
            3: begin
                exp_q[cyc+1] = '{v: 1'b1, cs0: 1'b0, a: rd_a, id: rd_id, rd: 1'b1};
                next_free = cyc + 1 + RDG;
                rd_req = 1'b0;
            end
            default: ;
        endcase
        exp_q.delete(cyc);
        p = pend + ((cyc % REFI == 0) ? 1 : 0) - dec;
        pend = (p > MAXP) ? MAXP : p;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int p_rd, input int p_reg);
        for (int i = 0; i < n; i++) begin
            gen(p_rd, p_reg);
            step();
        end
    endtask

    initial begin
        rd_req = 1'b0; rd_a = '0; rd_id = '0;
        reg_req = 1'b0; reg_w = 1'b0; reg_n = '0; reg_d = '0;
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs", 64'({dut_slot(), bus.ref_busy, bus.ref_pending}), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Idle: first refresh lands in cycle 18 and occupies ref_busy for RFC cycles
        run(40, 0, 0);
        check_eq("first_ref_cyc", 64'(first_ref_cyc), 64'(18));

        // Register write 0x12 <= 0xA5
        reg_req = 1'b1; reg_w = 1'b1; reg_n = 8'h12; reg_d = 8'hA5;
        run(25, 0, 0);

        // Concurrent register read and bus read; register goes first
        rd_req = 1'b1; rd_a = 15'h1234; rd_id = 9'h1AB;
        reg_req = 1'b1; reg_w = 1'b0; reg_n = 8'h03; reg_d = 8'h00;
        run(30, 0, 0);
        check_eq("rd_done", 64'(rd_req), 64'(0));

        // Continuous reads: refresh debt climbs to the ceiling and is then forced out
        run(400, 100, 0);
        check_eq("pend_reached_max", 64'(max_pend), 64'(MAXP));

        // Random mix
        run(1500, 40, 10);

        // Reset while a register write sits between its two slots
        reg_req = 1'b1; reg_w = 1'b1; reg_n = 8'h5C; reg_d = 8'h3E;
        for (int i = 0; i < 100 && reg_req; i++) begin
            gen(0, 0);
            step();
        end
        check_eq("wr_fired", 64'(reg_req), 64'(0));
        drive();
        #1;
        check_eq("wr_slot1", 64'(dut_slot()),
                 64'(exp_q.exists(cyc) ? exp_q[cyc] : '0));
        rd_req = 1'b1; rd_a = 15'h0ACE; rd_id = 9'h055;
        drive();
        rst = 1'b0;
        #1;
        check_eq("async_rst_outs",
                 64'({bus.rd_ready, bus.reg_ready, dut_slot(), bus.ref_busy, bus.ref_pending}),
                 64'(0));
        @(posedge clk);
        #1;
        check_eq("no_data_slot",
                 64'({bus.rd_ready, bus.reg_ready, dut_slot(), bus.ref_busy, bus.ref_pending}),
                 64'(0));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step();
        check_eq("post_rst_grant", 64'(last_grant), 64'(3));
        run(300, 30, 15);

        check_eq("pend_ceiling", 64'(max_pend <= MAXP), 64'(1));
        $display("[TB] refreshes issued on a due cycle: %0d", due_on_ref);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
